// File: rtl/addr_gen_2d_if.sv
// addr_gen_2d_if: address stream between the 2D address generator and the
// operand SRAM read port.
//   out_valid  generator -> consumer, tuple valid
//   out_ready  consumer  -> generator, tuple accepted
//   addr/row/col/last  tuple payload (last marks the final tile element)
// Modports: master (generator side), slave (consumer side).
interface addr_gen_2d_if #(
    parameter int AW = 12,
    parameter int DW = 12
);
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] row;
    logic [DW-1:0] col;
    logic          last;

    modport master (
        output out_valid, addr, row, col, last,
        input  out_ready
    );

    modport slave (
        input  out_valid, addr, row, col, last,
        output out_ready
    );
endinterface

// File: rtl/addr_gen_2d.sv
// addr_gen_2d: walks a (row_max+1) x (col_max+1) tile of row-pitched memory
// and emits one {addr,row,col} tuple per accepted valid/ready beat.
// Addresses are built incrementally (no multiplier) and wrap modulo 2^AW.
//
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   start         launch a traversal (honoured only when idle)
//   base          address of element (0,0)
//   row_max       last row index
//   col_max       last column index
//   pitch         address distance between consecutive rows
//   col_major     traversal order (only with ADDR_GEN_2D_COLMAJOR_EN)
//   busy          traversal in progress
//   done          one-cycle pulse after the final tuple is accepted
//   stream        address stream (addr_gen_2d_if.master)
//
// Build option: define ADDR_GEN_2D_COLMAJOR_EN to add the col_major port and
// column-major stepping; otherwise traversal is always row-major.
module addr_gen_2d #(
    parameter int AW = 12,
    parameter int DW = 12
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [DW-1:0] row_max,
    input  logic [DW-1:0] col_max,
    input  logic [AW-1:0] pitch,
`ifdef ADDR_GEN_2D_COLMAJOR_EN
    input  logic          col_major,
`endif
    output logic          busy,
    output logic          done,
    addr_gen_2d_if.master stream
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] base_q;
    logic [AW-1:0] pitch_q;
    logic [DW-1:0] row_max_q;
    logic [DW-1:0] col_max_q;
`ifdef ADDR_GEN_2D_COLMAJOR_EN
    logic          col_major_q;
`endif

    logic [AW-1:0] row_off;   // running row*pitch, accumulated
    logic [AW-1:0] addr_q;
    logic [DW-1:0] row_q;
    logic [DW-1:0] col_q;
    logic          last_q;
    logic          done_q;

    logic [AW-1:0] row_off_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] row_n;
    logic [DW-1:0] col_n;
    logic          last_n;
    logic          fire;

    assign fire = (state == RUN) && stream.out_ready;

    // Position after the current tuple is accepted. Only used when fire is
    // high and the current tuple is not the last one, so the increments below
    // never step past row_max/col_max.
    always_comb begin
        row_off_n = row_off;
        addr_n    = addr_q;
        row_n     = row_q;
        col_n     = col_q;
`ifdef ADDR_GEN_2D_COLMAJOR_EN
        if (col_major_q) begin
            if (row_q < row_max_q) begin
                row_n     = row_q + DW'(1);
                row_off_n = row_off + pitch_q;
                addr_n    = addr_q + pitch_q;
            end else begin
                row_n     = '0;
                row_off_n = '0;
                col_n     = col_q + DW'(1);
                addr_n    = base_q + AW'(col_n);
            end
        end else
`endif
        begin
            if (col_q < col_max_q) begin
                col_n  = col_q + DW'(1);
                addr_n = addr_q + AW'(1);
            end else begin
                col_n     = '0;
                row_n     = row_q + DW'(1);
                row_off_n = row_off + pitch_q;
                addr_n    = base_q + row_off_n;
            end
        end
        last_n = (row_n == row_max_q) && (col_n == col_max_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            base_q    <= '0;
            pitch_q   <= '0;
            row_max_q <= '0;
            col_max_q <= '0;
`ifdef ADDR_GEN_2D_COLMAJOR_EN
            col_major_q <= 1'b0;
`endif
            row_off   <= '0;
            addr_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        base_q    <= base;
                        pitch_q   <= pitch;
                        row_max_q <= row_max;
                        col_max_q <= col_max;
`ifdef ADDR_GEN_2D_COLMAJOR_EN
                        col_major_q <= col_major;
`endif
                        row_off   <= '0;
                        addr_q    <= base;
                        row_q     <= '0;
                        col_q     <= '0;
                        // a 1x1 tile's first tuple is also its last
                        last_q    <= (row_max == '0) && (col_max == '0);
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (last_q) begin
                            state   <= IDLE;
                            done_q  <= 1'b1;
                            row_off <= '0;
                            addr_q  <= '0;
                            row_q   <= '0;
                            col_q   <= '0;
                            last_q  <= 1'b0;
                        end else begin
                            row_off <= row_off_n;
                            addr_q  <= addr_n;
                            row_q   <= row_n;
                            col_q   <= col_n;
                            last_q  <= last_n;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy             = (state == RUN);
    assign done             = done_q;
    assign stream.out_valid = (state == RUN);
    assign stream.addr      = addr_q;
    assign stream.row       = row_q;
    assign stream.col       = col_q;
    assign stream.last      = last_q;

endmodule
